// File: rtl/dmem_cache_stage_if.sv
// Backing-memory request/response bus between the data-cache stage and memory.
interface dmem_cache_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/dmem_cache_stage.sv
// Memory-access stage: direct-mapped, one-word-per-line, write-through,
// no-write-allocate data cache. Stall freezes upstream stages while a read
// miss or a write-through is outstanding on the backing-memory bus.
module dmem_cache_stage #(
   parameter int INDEX_BITS = 4
) (
   input  logic                clock,
   input  logic                rst,
   input  logic [2:0]          Mreg,
   input  logic [31:0]         ALUreg,
   input  logic [31:0]         WriteDataOut,
   output logic [31:0]         ReadData,
   output logic                Stall,
   dmem_cache_stage_if.master  mem
);

   localparam int TAG_BITS = 30 - INDEX_BITS;
   localparam int LINES    = 1 << INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [LINES-1:0]     valid_q;
   logic [TAG_BITS-1:0]  tag_q  [LINES];
   logic [31:0]          data_q [LINES];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   addr_tag;
   logic                  is_wr;
   logic                  is_rd;
   logic                  hit;
   logic                  fill;
   logic                  wr_update;

   // Branch bit and byte offset are carried on the bus but have no role here.
   logic unused_bits;
   assign unused_bits = ^{Mreg[2], ALUreg[1:0]};

   assign idx      = ALUreg[INDEX_BITS+1:2];
   assign addr_tag = ALUreg[31:INDEX_BITS+2];

   // A store wins over a simultaneous load request.
   assign is_wr = Mreg[0];
   assign is_rd = Mreg[1] & ~Mreg[0];

   assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
   assign fill      = (state_q == RD_MISS) && mem.mem_ready;
   assign wr_update = (state_q == WR_THRU) && mem.mem_ready && hit;

   // Bus outputs decode straight from state so an async reset drops mem_req at once.
   assign mem.mem_req   = (state_q != IDLE);
   assign mem.mem_we    = (state_q == WR_THRU);
   assign mem.mem_addr  = (state_q != IDLE) ? {ALUreg[31:2], 2'b00} : 32'h0;
   assign mem.mem_wdata = (state_q == WR_THRU) ? WriteDataOut : 32'h0;

   // Classify the access, pick the next state and produce Stall/ReadData.
   always_comb begin
      state_d  = state_q;
      Stall    = 1'b0;
      ReadData = 32'h0;
      case (state_q)
         IDLE: begin
            if (is_wr) begin
               Stall   = 1'b1;
               state_d = WR_THRU;
            end else if (is_rd) begin
               if (hit) begin
                  ReadData = data_q[idx];
               end else begin
                  Stall   = 1'b1;
                  state_d = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            Stall = ~mem.mem_ready;
            if (mem.mem_ready) begin
               ReadData = mem.mem_rdata;
               state_d  = IDLE;
            end
         end
         WR_THRU: begin
            Stall = ~mem.mem_ready;
            if (mem.mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and line-valid bits; reset aborts any in-flight access.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         if (fill) begin
            valid_q[idx] <= 1'b1;
         end
      end
   end

   // Tag/data arrays: fill on read-miss completion, update on write-through hit.
   always_ff @(posedge clock) begin
      if (fill) begin
         tag_q[idx]  <= addr_tag;
         data_q[idx] <= mem.mem_rdata;
      end else if (wr_update) begin
         data_q[idx] <= WriteDataOut;
      end
   end

endmodule

// File: tb/tb_dmem_cache_stage.sv
// Scoreboard bench for dmem_cache_stage: directed accesses push expected
// responses and bus transactions; a monitor pops and compares them.
module tb_dmem_cache_stage;

   logic        clock;
   logic        rst;
   logic [2:0]  Mreg;
   logic [31:0] ALUreg;
   logic [31:0] WriteDataOut;
   logic [31:0] ReadData;
   logic        Stall;

   dmem_cache_stage_if mif ();

   dmem_cache_stage #(.INDEX_BITS(4)) dut (
      .clock        (clock),
      .rst          (rst),
      .Mreg         (Mreg),
      .ALUreg       (ALUreg),
      .WriteDataOut (WriteDataOut),
      .ReadData     (ReadData),
      .Stall        (Stall),
      .mem          (mif)
   );

   typedef struct {
      logic [31:0] rd;
      int          stall;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } memtx_t;

   rsp_t   rsp_q[$];
   memtx_t mem_q[$];

   int          checks   = 0;
   int          failures = 0;
   int          stall_cnt = 0;
   int          cnt = 0;
   int          cur_lat = 0;
   logic [31:0] cur_rdata = 32'h0;
   logic        acc_active = 1'b0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Memory responder: ready pulses after cur_lat wait cycles of mem_req.
   initial begin
      mif.mem_ready = 1'b0;
      mif.mem_rdata = 32'h0;
      forever begin
         @(posedge clock or posedge rst);
         if (rst) begin
            cnt = 0;
            mif.mem_ready = 1'b0;
         end else begin
            #1;
            if (mif.mem_ready) begin
               mif.mem_ready = 1'b0;
               cnt = 0;
            end else if (mif.mem_req) begin
               if (cnt == cur_lat) begin
                  mif.mem_ready = 1'b1;
                  mif.mem_rdata = cur_rdata;
               end else begin
                  cnt++;
               end
            end
         end
      end
   end

   // Monitor: compare completed accesses and bus transactions against the queues.
   always @(negedge clock) begin
      rsp_t   r;
      memtx_t m;
      if (!rst && acc_active) begin
         if (Stall) begin
            stall_cnt++;
         end else begin
            if (rsp_q.size() == 0) begin
               chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
               r = rsp_q.pop_front();
               chk("ReadData", ReadData, r.rd);
               chk("stall_cycles", stall_cnt, r.stall);
            end
            stall_cnt = 0;
         end
      end else begin
         stall_cnt = 0;
      end
      if (!rst && mif.mem_req && mif.mem_ready) begin
         if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", 32'd1, 32'd0);
         end else begin
            m = mem_q.pop_front();
            chk("mem_we", {31'd0, mif.mem_we}, {31'd0, m.we});
            chk("mem_addr", mif.mem_addr, m.addr);
            if (m.we) chk("mem_wdata", mif.mem_wdata, m.wdata);
         end
      end
   end

   // One access held until Stall drops; expectations pushed before driving.
   task automatic access(input logic [2:0] m, input logic [31:0] a, input logic [31:0] wd,
                         input int lat, input logic [31:0] rdat,
                         input logic [31:0] exp_rd, input int exp_stall,
                         input logic exp_mem, input logic exp_we, input logic [31:0] exp_addr);
      rsp_t   r;
      memtx_t t;
      int     n;
      r.rd = exp_rd;
      r.stall = exp_stall;
      rsp_q.push_back(r);
      if (exp_mem) begin
         t.we = exp_we;
         t.addr = exp_addr;
         t.wdata = wd;
         mem_q.push_back(t);
      end
      @(posedge clock);
      #2;
      Mreg = m;
      ALUreg = a;
      WriteDataOut = wd;
      cur_lat = lat;
      cur_rdata = rdat;
      acc_active = 1'b1;
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (Stall && n < 64);
      if (Stall) chk("access_timeout", 32'd1, 32'd0);
      @(posedge clock);
      #2;
      Mreg = 3'b000;
      acc_active = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      Mreg = 3'b000;
      ALUreg = 32'h0;
      WriteDataOut = 32'h0;
      repeat (3) @(posedge clock);
      #2;
      chk("rst_Stall", {31'd0, Stall}, 32'd0);
      chk("rst_ReadData", ReadData, 32'h0);
      chk("rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mif.mem_we}, 32'd0);
      chk("rst_mem_addr", mif.mem_addr, 32'h0);
      chk("rst_mem_wdata", mif.mem_wdata, 32'h0);
      rst = 1'b0;

      //     Mreg    addr          wdata         lat rdata         exp_rd        stall mem we addr
      access(3'b010, 32'h0000_0040, 32'h0,        3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 1, 0, 32'h40);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h0,         32'hDEAD_BEEF, 0, 0, 0, 32'h0);
      access(3'b001, 32'h0000_0040, 32'h1234_5678, 1, 32'h0,        32'h0,         2, 1, 1, 32'h40);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h0,         32'h1234_5678, 0, 0, 0, 32'h0);
      access(3'b001, 32'h0000_0080, 32'hAAAA_5555, 0, 32'h0,        32'h0,         1, 1, 1, 32'h80);
      access(3'b010, 32'h0000_0080, 32'h0,        2, 32'h0BAD_F00D, 32'h0BAD_F00D, 3, 1, 0, 32'h80);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 32'h40);
      access(3'b010, 32'h0000_0440, 32'h0,        1, 32'hCAFE_0440, 32'hCAFE_0440, 2, 1, 0, 32'h440);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h1234_5678, 32'h1234_5678, 1, 1, 0, 32'h40);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h0,         32'h1234_5678, 0, 0, 0, 32'h0);
      access(3'b011, 32'h0000_0040, 32'h55AA_55AA, 1, 32'h0,        32'h0,         2, 1, 1, 32'h40);
      access(3'b010, 32'h0000_0040, 32'h0,        0, 32'h0,         32'h55AA_55AA, 0, 0, 0, 32'h0);
      access(3'b100, 32'h0000_0040, 32'h0,        0, 32'h0,         32'h0,         0, 0, 0, 32'h0);
      access(3'b010, 32'h0000_0047, 32'h0,        0, 32'h4444_4444, 32'h4444_4444, 1, 1, 0, 32'h44);
      access(3'b010, 32'h0000_0044, 32'h0,        0, 32'h0,         32'h4444_4444, 0, 0, 0, 32'h0);

      // Reset in the middle of a read miss must abort the request immediately.
      @(posedge clock);
      #2;
      Mreg = 3'b010;
      ALUreg = 32'h0000_0100;
      cur_lat = 10;
      cur_rdata = 32'h0100_0100;
      repeat (3) @(posedge clock);
      #3;
      chk("abort_req_before", {31'd0, mif.mem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("abort_req_dropped", {31'd0, mif.mem_req}, 32'd0);
      chk("abort_we", {31'd0, mif.mem_we}, 32'd0);
      chk("abort_ReadData", ReadData, 32'h0);
      @(posedge clock);
      #2;
      rst = 1'b0;
      Mreg = 3'b000;

      access(3'b010, 32'h0000_0100, 32'h0,        1, 32'h0100_0100, 32'h0100_0100, 2, 1, 0, 32'h100);
      access(3'b010, 32'h0000_0044, 32'h0,        0, 32'h4444_4444, 32'h4444_4444, 1, 1, 0, 32'h44);

      repeat (2) @(posedge clock);
      chk("rsp_queue_empty", rsp_q.size(), 32'd0);
      chk("mem_queue_empty", mem_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
